priority_mux_6to1: RTL and testbench
====================================

Name: priority_mux_6to1

Overview:
- Registered 6-input priority multiplexer.
- A 5-bit select vector chooses one of six WIDTH-bit data inputs; the highest set select bit wins, and d0 is the default when no bit is set.
- Output is registered (1-cycle latency) with a valid flag and a binary index of the chosen input.
- Used as a generic data-steering element in datapaths that need deterministic priority resolution.

Parameters:
- WIDTH, 8, bit width of each data input and of d_out.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies d0..d5 and sel in the current cycle.
- d0  input  WIDTH  data input 0 (default when sel == 0).
- d1  input  WIDTH  data input 1 (selected by sel[0]).
- d2  input  WIDTH  data input 2 (selected by sel[1]).
- d3  input  WIDTH  data input 3 (selected by sel[2]).
- d4  input  WIDTH  data input 4 (selected by sel[3]).
- d5  input  WIDTH  data input 5 (selected by sel[4]).
- sel  input  5  priority select vector; bit 4 highest priority.
- d_out  output  WIDTH  registered selected data.
- sel_idx  output  3  registered index (0..5) of the input driven onto d_out.
- out_valid  output  1  high for one cycle per accepted input.

Behaviour:
- Clocking: single clock domain; reset is synchronous and active-high, and takes precedence over all other inputs at the clock edge.
- Reset values: d_out = 0, sel_idx = 0, out_valid = 0.
- Priority resolution is combinational, on the current-cycle sel:
  - sel[4]=1 -> d5, idx 5.
  - else sel[3]=1 -> d4, idx 4.
  - else sel[2]=1 -> d3, idx 3.
  - else sel[1]=1 -> d2, idx 2.
  - else sel[0]=1 -> d1, idx 1.
  - else -> d0, idx 0.
- Lower-priority sel bits are don't-care once a higher bit is set; multiple set bits never cause an error or blend.
- Latency: when in_valid=1 at rising edge N (rst=0), d_out, sel_idx and out_valid=1 are presented after edge N, i.e. visible in cycle N+1.
- When in_valid=0 at an edge (rst=0): out_valid goes to 0; d_out and sel_idx hold their previous values.
- Back-to-back operation: in_valid may be high every cycle; one result per cycle, no stalls, no backpressure.
- Reset mid-stream: an input accepted on the same edge as rst=1 is discarded; outputs take reset values.
- Data is passed bit-exact, with no sign or width conversion. All WIDTH bits are transferred, for any WIDTH >= 1.
- No X propagation from unselected inputs: d_out depends only on the selected input.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary inputs and in_valid=1 -> d_out=0x00, sel_idx=0, out_valid=0 after each edge.
- Default select: d0=0x55, others 0x00, sel=5'b00000, in_valid=1 -> next cycle d_out=0x55, sel_idx=0, out_valid=1.
- Top priority with all bits set: d5=0xFF, others 0x00, sel=5'b11111 -> d_out=0xFF, sel_idx=5.
- Masking lower bits: d2=0xF0, d1=0x0F, others 0, sel=5'b00011 -> d_out=0xF0, sel_idx=2. Repeat the identical vector on the next cycle -> same result, out_valid stays 1.
- Walking one-hot select: d0..d5 = 0x10..0x15, sel = 00001, 00010, 00100, 01000, 10000 on consecutive cycles -> d_out = 0x11, 0x12, 0x13, 0x14, 0x15 with 1-cycle lag; then in_valid=0 -> out_valid=0, d_out holds 0x15.
- Random regression: at least 10 random vectors (random data, random sel) checked against the priority reference model one cycle later, including rst asserted mid-sequence -> zero mismatches; the reset cycle yields the reset values.

Source files
------------

// File: rtl/priority_mux_6to1.sv
// Registered 6-input priority multiplexer.
// The highest set bit of sel picks one of d1..d5. d0 is the default when sel is zero.
// Result, index and valid flag appear one cycle after the input is accepted.
module priority_mux_6to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [4:0]       sel,
    output logic [WIDTH-1:0] d_out,
    output logic [2:0]       sel_idx,
    output logic             out_valid
);

    // Single register stage. The valid bit travels down vld_pipe alongside the data.
    localparam int STAGES = 1;

    logic [WIDTH-1:0]  mux_data;
    logic [2:0]        mux_idx;
    logic [STAGES:0]   vld_pipe;

    assign vld_pipe[0] = in_valid;

    // Priority resolution: sel[4] is the strongest bit. Lower bits are ignored once a higher bit wins.
    // Only the chosen input reaches mux_data, so unselected inputs cannot leak X.
    always_comb begin
        mux_data = d0;
        mux_idx  = 3'd0;
        if (sel[4]) begin
            mux_data = d5;
            mux_idx  = 3'd5;
        end else if (sel[3]) begin
            mux_data = d4;
            mux_idx  = 3'd4;
        end else if (sel[2]) begin
            mux_data = d3;
            mux_idx  = 3'd3;
        end else if (sel[1]) begin
            mux_data = d2;
            mux_idx  = 3'd2;
        end else if (sel[0]) begin
            mux_data = d1;
            mux_idx  = 3'd1;
        end
    end

    // Valid shift register. Reset drops any input accepted on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        end
    end

    // Output data and index. Load on an accepted input, otherwise hold the previous result.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out   <= '0;
            sel_idx <= 3'd0;
        end else if (in_valid) begin
            d_out   <= mux_data;
            sel_idx <= mux_idx;
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_priority_mux_6to1.sv
// Scoreboard bench for priority_mux_6to1.
// The stimulus side pushes the expected output state for each clock edge into a queue.
// A monitor pops one entry on each falling edge and compares it with the DUT outputs.
module tb_priority_mux_6to1;

    localparam int WIDTH = 8;

    typedef struct {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [2:0]       idx;
        string            tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] d [6];
    logic [4:0]       sel;
    logic [WIDTH-1:0] d_out;
    logic [2:0]       sel_idx;
    logic             out_valid;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the last data and index the output would be holding.
    logic [WIDTH-1:0] held_data = '0;
    logic [2:0]       held_idx  = '0;

    always #5 clk = ~clk;

    priority_mux_6to1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .d4        (d[4]),
        .d5        (d[5]),
        .sel       (sel),
        .d_out     (d_out),
        .sel_idx   (sel_idx),
        .out_valid (out_valid)
    );

    // Winning index = position of the highest set bit plus one (0 when sel is zero).
    function automatic int winner(input logic [4:0] s);
        int n = 0;
        int t = int'(s);
        while (t != 0) begin
            n++;
            t = t >> 1;
        end
        return n;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then record what the DUT must show.
    task automatic drive(input logic r, input logic v, input logic [4:0] s, input string tag);
        exp_t e;
        int w;
        rst = r;
        in_valid = v;
        sel = s;
        w = winner(s);
        @(posedge clk);
        if (r) begin
            held_data = '0;
            held_idx  = '0;
            e.valid   = 1'b0;
        end else begin
            if (v) begin
                held_data = d[w];
                held_idx  = 3'(w);
            end
            e.valid = v;
        end
        e.data = held_data;
        e.idx  = held_idx;
        e.tag  = tag;
        q.push_back(e);
        #1;
    endtask

    task automatic set_data(input logic [WIDTH-1:0] a0, a1, a2, a3, a4, a5);
        d[0] = a0; d[1] = a1; d[2] = a2; d[3] = a3; d[4] = a4; d[5] = a5;
    endtask

    // Monitor: compare every recorded edge on the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (out_valid !== e.valid) begin
                    errors++;
                    $display("FAIL %s out_valid: got %b expected %b", e.tag, out_valid, e.valid);
                end
                checks++;
                if (d_out !== e.data) begin
                    errors++;
                    $display("FAIL %s d_out: got %h expected %h", e.tag, d_out, e.data);
                end
                checks++;
                if (sel_idx !== e.idx) begin
                    errors++;
                    $display("FAIL %s sel_idx: got %0d expected %0d", e.tag, sel_idx, e.idx);
                end
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1;
        in_valid = 1'b1;
        sel = '0;
        set_data(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6);
        #2;

        // Reset held for two edges with live inputs.
        drive(1'b1, 1'b1, 5'b10101, "reset0");
        drive(1'b1, 1'b1, 5'b00011, "reset1");

        // Default select.
        set_data(8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 5'b00000, "default");

        // All select bits set.
        set_data(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        drive(1'b0, 1'b1, 5'b11111, "all_bits");

        // Lower bit masked, then the same vector again.
        set_data(8'h00, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 5'b00011, "mask0");
        drive(1'b0, 1'b1, 5'b00011, "mask1");

        // Walking one-hot, then idle while the output holds.
        set_data(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 5'(1 << i), "walk");
        drive(1'b0, 1'b0, 5'b00001, "idle_hold");
        drive(1'b0, 1'b0, 5'b10000, "idle_hold2");

        // Random regression with occasional reset and idle cycles.
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 6; k++) d[k] = WIDTH'($urandom);
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  5'($urandom), "random");
        end
        // A reset in the middle of an active stream.
        drive(1'b0, 1'b1, 5'b01000, "pre_rst");
        drive(1'b1, 1'b1, 5'b10000, "mid_rst");
        drive(1'b0, 1'b0, 5'b10000, "post_rst");

        // Drain the scoreboard with a bounded wait.
        budget = 20;
        while (q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
